string_led_sequencer: RTL and testbench



---
 rtl/string_led_pkg.sv | 21 ++
 rtl/string_led_sequencer_bit_timer.sv | 34 +++
 rtl/string_led_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_string_led_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/string_led_pkg.sv
// Shared types and constants for the string-LED sequencer.
// The default timings target WS2812 parts driven from a 50 MHz clock.
package string_led_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SHIFT,
        LATCH
    } state_t;

    localparam int MIN_TBIT   = 2;
    localparam int MIN_TRESET = 1;

    localparam int DEF_T0H    = 20;
    localparam int DEF_T1H    = 40;
    localparam int DEF_TBIT   = 63;
    localparam int DEF_TRESET = 2500;

endpackage

// File: rtl/string_led_sequencer_bit_timer.sv
// Times one NRZ bit: the line is high for th ticks, and the bit lasts eff_tbit ticks.
// The tick counter holds at zero whenever run is low.
module led_bit_timer #(
    parameter int TSIZE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             bit_val,
    input  logic [TSIZE-1:0] th0,
    input  logic [TSIZE-1:0] th1,
    input  logic [TSIZE-1:0] eff_tbit,
    output logic             level,
    output logic             bit_end
);

    logic [TSIZE-1:0] tick_cnt;
    logic [TSIZE-1:0] th;

    always_comb begin
        th      = bit_val ? th1 : th0;
        level   = run && (tick_cnt < th);
        bit_end = run && (tick_cnt == eff_tbit - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst || !run || bit_end) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/string_led_sequencer.sv
// Streams SRAM words MSB-first onto a WS281x-style NRZ LED line.
// The design supports programmable timing, multiple passes, a latch gap and abort.
module string_led_sequencer
    import string_led_pkg::*;
#(
    parameter int ASIZE = 32,
    parameter int TSIZE = 16,
    parameter int DSIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             controller_en,
    input  logic             polarity,
    input  logic [TSIZE-1:0] t0h,
    input  logic [TSIZE-1:0] t1h,
    input  logic [TSIZE-1:0] tbit,
    input  logic [TSIZE-1:0] treset,
    input  logic [3:0]       w_count,
    input  logic [ASIZE-1:0] w_first,
    input  logic [ASIZE-1:0] w_last,
    input  logic             start,
    output logic             progress,
    output logic             done,
    output logic             error,
    output logic             cs_n,
    output logic [ASIZE-1:0] addr,
    input  logic [DSIZE-1:0] rdata,
    output logic             led_out
);

    localparam int BW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DSIZE - 1);
    localparam logic [BW-1:0] PRE_BIT  = BW'(DSIZE - 2);

    function automatic logic [TSIZE-1:0] sat_floor(input logic [TSIZE-1:0] v,
                                                   input logic [TSIZE-1:0] lo);
        return (v < lo) ? lo : v;
    endfunction

    function automatic logic [TSIZE-1:0] sat_ceil(input logic [TSIZE-1:0] v,
                                                  input logic [TSIZE-1:0] hi);
        return (v > hi) ? hi : v;
    endfunction

    state_t           state, state_nxt;
    logic [ASIZE-1:0] first_s, last_s, idx;
    logic [3:0]       pass_cnt;
    logic [TSIZE-1:0] th0_s, th1_s, tbit_s, treset_s, lat_cnt;
    logic [TSIZE-1:0] tbit_eff;
    logic [BW-1:0]    bit_cnt;
    logic [DSIZE-1:0] shreg, pbuf, word_in;
    logic             rd_vld_p1;
    logic             start_ok, start_bad, abort;
    logic             bit_end, line_lvl, last_bit, more_words, lat_end;

    always_comb begin
        tbit_eff   = sat_floor(tbit, TSIZE'(MIN_TBIT));
        start_bad  = start && controller_en && ((w_count == 4'd0) || (w_first > w_last));
        start_ok   = start && controller_en && !start_bad;
        abort      = !controller_en && (state != IDLE);
        last_bit   = (bit_cnt == LAST_BIT);
        more_words = (idx < last_s);
        lat_end    = (lat_cnt == treset_s - 1'b1);
        // Read data is only guaranteed in the cycle after the strobe, so it is also held in pbuf.
        word_in    = rd_vld_p1 ? rdata : pbuf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = FETCH;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = SHIFT;
            SHIFT:   if (bit_end && last_bit && !more_words) state_nxt = LATCH;
            LATCH:   if (lat_end) state_nxt = (pass_cnt > 4'd1) ? FETCH : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            progress  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cs_n      <= 1'b1;
            addr      <= '0;
            idx       <= '0;
            pass_cnt  <= '0;
            bit_cnt   <= '0;
            lat_cnt   <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            done      <= 1'b0;
            error     <= 1'b0;
            cs_n      <= 1'b1;
            rd_vld_p1 <= ~cs_n;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        progress <= 1'b1;
                        cs_n     <= 1'b0;
                        addr     <= w_first;
                        idx      <= w_first;
                        pass_cnt <= w_count;
                        bit_cnt  <= '0;
                        lat_cnt  <= '0;
                    end
                    if (start_bad) error <= 1'b1;
                end
                SHIFT: begin
                    if (bit_end) begin
                        if (last_bit) begin
                            bit_cnt <= '0;
                            lat_cnt <= '0;
                            if (more_words) idx <= idx + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        // Prefetch so the strobe lands on the first tick of the final bit.
                        if (bit_cnt == PRE_BIT && more_words) begin
                            cs_n <= 1'b0;
                            addr <= idx + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_end) begin
                        lat_cnt  <= '0;
                        pass_cnt <= pass_cnt - 1'b1;
                        if (pass_cnt > 4'd1) begin
                            idx  <= first_s;
                            cs_n <= 1'b0;
                            addr <= first_s;
                        end else begin
                            done     <= 1'b1;
                            progress <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
            if (abort) begin
                progress <= 1'b0;
                cs_n     <= 1'b1;
                done     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start_ok) begin
            first_s  <= w_first;
            last_s   <= w_last;
            tbit_s   <= tbit_eff;
            th0_s    <= sat_ceil(t0h, tbit_eff - 1'b1);
            th1_s    <= sat_ceil(t1h, tbit_eff - 1'b1);
            treset_s <= sat_floor(treset, TSIZE'(MIN_TRESET));
        end
        if (rd_vld_p1) pbuf <= rdata;
        if (state == WAIT) begin
            shreg <= word_in;
        end else if (state == SHIFT && bit_end) begin
            shreg <= last_bit ? word_in : (shreg << 1);
        end
    end

    led_bit_timer #(
        .TSIZE(TSIZE)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (state == SHIFT),
        .bit_val  (shreg[DSIZE-1]),
        .th0      (th0_s),
        .th1      (th1_s),
        .eff_tbit (tbit_s),
        .level    (line_lvl),
        .bit_end  (bit_end)
    );

    assign led_out = polarity ^ line_lvl;

endmodule

// File: tb/tb_string_led_sequencer.sv
// Directed bench for string_led_sequencer: it records per-cycle output samples after each start
// and compares them against hand-computed waveforms.
module tb_string_led_sequencer;

    logic        clk = 1'b0;
    logic        rst, controller_en, polarity, start;
    logic [15:0] t0h, t1h, tbit, treset;
    logic [3:0]  w_count;
    logic [31:0] w_first, w_last;
    logic        progress, done, error, cs_n, led_out;
    logic [31:0] addr;
    logic [7:0]  rdata = 8'h00;
    logic [7:0]  mem [0:15];

    int checks = 0;
    int errors = 0;

    logic        lv_a [0:1023];
    logic        pr_a [0:1023];
    logic        dn_a [0:1023];
    logic        er_a [0:1023];
    logic        cs_a [0:1023];
    logic [31:0] ad_a [0:1023];
    int          rd_q [$];

    int exp_hi [8]  = '{7, 3, 7, 3, 3, 7, 3, 7};
    int exp_rd2 [6] = '{4, 5, 6, 4, 5, 6};
    int exp_rd6 [3] = '{4, 5, 6};

    string_led_sequencer #(.ASIZE(32), .TSIZE(16), .DSIZE(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .controller_en (controller_en),
        .polarity      (polarity),
        .t0h           (t0h),
        .t1h           (t1h),
        .tbit          (tbit),
        .treset        (treset),
        .w_count       (w_count),
        .w_first       (w_first),
        .w_last        (w_last),
        .start         (start),
        .progress      (progress),
        .done          (done),
        .error         (error),
        .cs_n          (cs_n),
        .addr          (addr),
        .rdata         (rdata),
        .led_out       (led_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!cs_n) rdata <= mem[addr[3:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Count samples of signal sel (0 led,1 progress,2 done,3 error,4 cs_n) equal to v in [a,b].
    function automatic int cnt(input int sel, input int a, input int b, input logic v);
        int n = 0;
        for (int i = a; i <= b; i++) begin
            case (sel)
                0: n += (lv_a[i] == v) ? 1 : 0;
                1: n += (pr_a[i] == v) ? 1 : 0;
                2: n += (dn_a[i] == v) ? 1 : 0;
                3: n += (er_a[i] == v) ? 1 : 0;
                default: n += (cs_a[i] == v) ? 1 : 0;
            endcase
        end
        return n;
    endfunction

    function automatic int leading_high(input int a, input int len);
        int n = 0;
        while (n < len && lv_a[a+n] == 1'b1) n++;
        return n;
    endfunction

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
    endtask

    task automatic capture(input int n, input int abort_at, input int restart_at, input int rst_at);
        rd_q.delete();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            lv_a[k] = led_out;
            pr_a[k] = progress;
            dn_a[k] = done;
            er_a[k] = error;
            cs_a[k] = cs_n;
            ad_a[k] = addr;
            if (!cs_n) rd_q.push_back(int'(addr));
            if (k == 1) start = 1'b0;
            if (k == abort_at) controller_en = 1'b0;
            if (k == restart_at) start = 1'b1;
            if (k == restart_at + 1) start = 1'b0;
            if (k == rst_at) rst = 1'b1;
            if (k == rst_at + 1) rst = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5; mem[1] = 8'hF0; mem[2] = 8'h0F; mem[3] = 8'h55;
        mem[4] = 8'h3C; mem[5] = 8'h81; mem[6] = 8'hFF;
        rst = 1'b1; controller_en = 1'b1; polarity = 1'b0; start = 1'b0;
        t0h = 16'd3; t1h = 16'd7; tbit = 16'd10; treset = 16'd20;
        w_count = 4'd1; w_first = 32'd0; w_last = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_progress", progress, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_addr", addr, 0);
        check("rst_led", led_out, 0);

        // Single word 0xA5, one pass
        kick();
        capture(110, 0, 0, 0);
        check("t1_progress_c1", pr_a[1], 1);
        check("t1_cs_n_c1", cs_a[1], 0);
        check("t1_addr_c1", ad_a[1], 0);
        check("t1_nreads", rd_q.size(), 1);
        check("t1_led_c2_idle", lv_a[2], 0);
        for (int b = 0; b < 8; b++) begin
            check($sformatf("t1_bit%0d_lead", b), leading_high(3 + 10*b, 10), exp_hi[b]);
            check($sformatf("t1_bit%0d_total", b), cnt(0, 3 + 10*b, 12 + 10*b, 1'b1), exp_hi[b]);
        end
        check("t1_latch_low", cnt(0, 83, 102, 1'b1), 0);
        check("t1_done_c103", dn_a[103], 1);
        check("t1_done_count", cnt(2, 1, 110, 1'b1), 1);
        check("t1_progress_c102", pr_a[102], 1);
        check("t1_progress_c103", pr_a[103], 0);
        check("t1_progress_span", cnt(1, 1, 110, 1'b1), 102);

        // Words 4..6, two passes
        w_first = 32'd4; w_last = 32'd6; w_count = 4'd2;
        kick();
        capture(560, 0, 0, 0);
        check("t2_nreads", rd_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < rd_q.size()) check($sformatf("t2_read%0d", i), rd_q[i], exp_rd2[i]);
        check("t2_prefetch_cs", cs_a[73], 0);
        check("t2_prefetch_addr", ad_a[73], 5);
        check("t2_gapless_p1", cnt(0, 3, 242, 1'b1) > 0 ? 1 : 0, 1);
        begin
            int gaps = 0;
            for (int j = 0; j < 24; j++) begin
                if (lv_a[3 + 10*j] != 1'b1) gaps++;
                if (lv_a[265 + 10*j] != 1'b1) gaps++;
            end
            check("t2_bit_starts_high", gaps, 0);
        end
        check("t2_w5_bit0", leading_high(83, 10), 7);
        check("t2_w5_bit1", leading_high(93, 10), 3);
        check("t2_latch1_low", cnt(0, 243, 262, 1'b1), 0);
        check("t2_refetch_cs", cs_a[263], 0);
        check("t2_refetch_addr", ad_a[263], 4);
        check("t2_latch2_low", cnt(0, 505, 524, 1'b1), 0);
        check("t2_done_c525", dn_a[525], 1);
        check("t2_done_count", cnt(2, 1, 560, 1'b1), 1);

        // Rejected starts
        w_first = 32'd5; w_last = 32'd3; w_count = 4'd1;
        kick();
        capture(10, 0, 0, 0);
        check("t3a_error_c1", er_a[1], 1);
        check("t3a_error_count", cnt(3, 1, 10, 1'b1), 1);
        check("t3a_progress", cnt(1, 1, 10, 1'b1), 0);
        check("t3a_cs_low", cnt(4, 1, 10, 1'b0), 0);
        w_first = 32'd0; w_last = 32'd0; w_count = 4'd0;
        kick();
        capture(10, 0, 0, 0);
        check("t3b_error_c1", er_a[1], 1);
        check("t3b_error_count", cnt(3, 1, 10, 1'b1), 1);
        check("t3b_progress", cnt(1, 1, 10, 1'b1), 0);
        check("t3b_cs_low", cnt(4, 1, 10, 1'b0), 0);

        // Abort during bit 3 of word 1, then restart
        w_first = 32'd1; w_last = 32'd3; w_count = 4'd1;
        kick();
        capture(140, 115, 0, 0);
        check("t4_progress_c115", pr_a[115], 1);
        check("t4_progress_c116", pr_a[116], 0);
        check("t4_led_c116", lv_a[116], 0);
        check("t4_cs_c116", cs_a[116], 1);
        check("t4_no_done", cnt(2, 1, 140, 1'b1), 0);
        check("t4_nreads", rd_q.size(), 2);
        controller_en = 1'b1;
        kick();
        capture(5, 0, 0, 0);
        check("t4_restart_cs", cs_a[1], 0);
        check("t4_restart_addr", ad_a[1], 1);
        controller_en = 1'b0;
        @(negedge clk);
        controller_en = 1'b1;

        // Inverted line, t1h clamped to tbit-1
        polarity = 1'b1; t1h = 16'd12;
        w_first = 32'd0; w_last = 32'd0; w_count = 4'd1;
        @(negedge clk);
        check("t5_idle_led", led_out, 1);
        kick();
        capture(110, 0, 0, 0);
        check("t5_bit0_low", cnt(0, 3, 12, 1'b0), 9);
        check("t5_bit0_tail", lv_a[12], 1);
        check("t5_bit1_low", cnt(0, 13, 22, 1'b0), 3);
        check("t5_latch_idle", cnt(0, 83, 110, 1'b0), 0);
        check("t5_done_c103", dn_a[103], 1);

        // Second start during progress is ignored
        polarity = 1'b0; t1h = 16'd7;
        w_first = 32'd4; w_last = 32'd6; w_count = 4'd1;
        kick();
        capture(280, 0, 50, 0);
        check("t6a_nreads", rd_q.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < rd_q.size()) check($sformatf("t6a_read%0d", i), rd_q[i], exp_rd6[i]);
        check("t6a_done_c263", dn_a[263], 1);
        check("t6a_done_count", cnt(2, 1, 280, 1'b1), 1);
        check("t6a_error_count", cnt(3, 1, 280, 1'b1), 0);

        // Reset mid-SHIFT
        kick();
        capture(300, 0, 0, 40);
        check("t6b_progress_c40", pr_a[40], 1);
        check("t6b_progress_c41", pr_a[41], 0);
        check("t6b_cs_c41", cs_a[41], 1);
        check("t6b_addr_c41", ad_a[41], 0);
        check("t6b_led_c41", lv_a[41], 0);
        check("t6b_done_c41", dn_a[41], 0);
        check("t6b_no_done", cnt(2, 1, 300, 1'b1), 0);
        check("t6b_cs_after", cnt(4, 41, 300, 1'b0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
